vlc_bit_packer: RTL and testbench

// Packs the variable-length codes emitted by one encoder channel (Y, Cb or Cr) into a

---
 rtl/icip_pkg.sv | 15 +
 rtl/vlc_merge.sv | 35 +++
 rtl/vlc_bit_packer.sv | 106 ++++++++++
 tb/tb_vlc_bit_packer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/icip_pkg.sv
// Shared constants and types for the VLC packing path.
//   CODE_W/LEN_W : encoder code and length widths
//   WORD_W       : packed output word width
//   ACC_W/FILL_W : bit accumulator width and its fill-count width
//   MLEN_W       : merge length width (covers pad lengths up to 31)
package icip_pkg;
  localparam int CODE_W = 26;
  localparam int LEN_W  = 5;
  localparam int WORD_W = 32;
  localparam int ACC_W  = 64;
  localparam int FILL_W = 7;
  localparam int MLEN_W = 6;

  typedef enum logic [1:0] {S_RUN, S_PAD, S_DRAIN, S_DONE} pack_state_t;
endpackage

// File: rtl/vlc_merge.sv
// Combinational bit merger for the left-justified accumulator.
//   acc/fill   : current accumulator and count of valid bits
//   code/len   : bits to append (only code[len-1:0] used, MSB first)
//   pop        : a word leaves this cycle; shift out before merging
//   acc_nxt/fill_nxt : updated accumulator and fill
module vlc_merge
  import icip_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [FILL_W-1:0] fill,
  input  logic [WORD_W-1:0] code,
  input  logic [MLEN_W-1:0] len,
  input  logic              pop,
  output logic [ACC_W-1:0]  acc_nxt,
  output logic [FILL_W-1:0] fill_nxt
);

  logic [ACC_W-1:0]  acc_s;
  logic [FILL_W-1:0] fill_s;
  logic [ACC_W-1:0]  bits;
  logic [FILL_W-1:0] sh;

  always_comb begin
    acc_s    = pop ? {acc[ACC_W-WORD_W-1:0], {WORD_W{1'b0}}} : acc;
    fill_s   = pop ? fill - FILL_W'(WORD_W) : fill;
    // Mask off code bits above len so stray high bits never land in the stream.
    bits     = ACC_W'(code) & ((ACC_W'(1) << len) - ACC_W'(1));
    // Place the new bits directly below the current fill; a shift of 64
    // (len==0, empty acc) yields zero, which is what we want.
    sh       = FILL_W'(ACC_W) - fill_s - FILL_W'(len);
    acc_nxt  = acc_s | (bits << sh);
    fill_nxt = fill_s + FILL_W'(len);
  end

endmodule

// File: rtl/vlc_bit_packer.sv
// Packs variable-length codes from one encoder channel into MSB-first
// 32-bit words with ready/valid handshakes, end-of-image flush and padding.
//   clk_0, rst (async, active low)
//   code_in/code_len/code_valid/code_ready : code input handshake
//   flush_req  : end-of-image pulse; pads to a word boundary and drains
//   word_out/word_valid/word_ready/word_last : packed word output
//   flush_done : pulses once after the final flushed word is taken
//   len_err    : sticky, a code longer than CODE_W was seen
//   word_count : words transferred since reset (wraps)
module vlc_bit_packer #(
  parameter int CODE_W   = icip_pkg::CODE_W,
  parameter int LEN_W    = icip_pkg::LEN_W,
  parameter int WORD_W   = icip_pkg::WORD_W,
  parameter int PAD_ONES = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_0,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic [LEN_W-1:0]  code_len,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              flush_req,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic              flush_done,
  output logic              len_err,
  output logic [CNT_W-1:0]  word_count
);
  import icip_pkg::*;

  pack_state_t       state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_m;
  logic [FILL_W-1:0] fill, fill_m;
  logic [WORD_W-1:0] m_code;
  logic [MLEN_W-1:0] m_len;
  logic              accept, pop, len_bad;

  assign code_ready = (state == S_RUN) && (fill <= FILL_W'(WORD_W));
  assign word_valid = (fill >= FILL_W'(WORD_W)) && (state != S_DONE);
  assign word_out   = acc[ACC_W-1 -: WORD_W];
  // In the flush states nothing more can be appended, so exactly one word left means last.
  assign word_last  = word_valid && (state == S_PAD || state == S_DRAIN)
                      && (fill == FILL_W'(WORD_W));
  assign flush_done = (state == S_DONE);
  assign accept     = code_valid && code_ready;
  assign pop        = word_valid && word_ready;
  assign len_bad    = code_len > LEN_W'(CODE_W);

  vlc_merge u_merge (
    .acc      (acc),
    .fill     (fill),
    .code     (m_code),
    .len      (m_len),
    .pop      (pop),
    .acc_nxt  (acc_m),
    .fill_nxt (fill_m)
  );

  always_comb begin
    state_nxt = state;
    m_code    = WORD_W'(code_in);
    m_len     = '0;
    case (state)
      S_RUN: begin
        // Over-length codes are accepted but contribute nothing.
        if (accept && !len_bad) m_len = MLEN_W'(code_len);
        if (flush_req) state_nxt = S_PAD;
      end
      S_PAD: begin
        m_code = {WORD_W{1'(PAD_ONES)}};
        m_len  = (fill[4:0] == 5'd0) ? '0 : MLEN_W'(WORD_W) - MLEN_W'(fill[4:0]);
        // Empty after pad/pop: either nothing was buffered or the one
        // remaining word (flagged last) just left.
        state_nxt = (fill_m == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (pop && fill == FILL_W'(WORD_W)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state      <= S_RUN;
      acc        <= '0;
      fill       <= '0;
      len_err    <= 1'b0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DONE) begin
        acc  <= '0;
        fill <= '0;
      end else begin
        acc  <= acc_m;
        fill <= fill_m;
      end
      if (pop) word_count <= word_count + CNT_W'(1);
      if (accept && len_bad) len_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed bench for vlc_bit_packer: streaming, flush/pad, backpressure,
// length errors and async reset mid-flush.
module tb_vlc_bit_packer;
  logic        clk_0 = 1'b0;
  logic        rst;
  logic [25:0] code_in;
  logic [4:0]  code_len;
  logic        code_valid, code_ready, flush_req;
  logic [31:0] word_out;
  logic        word_valid, word_ready, word_last, flush_done, len_err;
  logic [15:0] word_count;

  int tests = 0;
  int fails = 0;

  vlc_bit_packer #(.PAD_ONES(1)) dut (
    .clk_0(clk_0), .rst(rst), .code_in(code_in), .code_len(code_len),
    .code_valid(code_valid), .code_ready(code_ready), .flush_req(flush_req),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .word_last(word_last), .flush_done(flush_done), .len_err(len_err),
    .word_count(word_count)
  );

  always #5 clk_0 = ~clk_0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_0);
    #1;
  endtask

  // Present one code and hold it until accepted (bounded).
  task automatic send(input logic [25:0] c, input logic [4:0] l);
    code_in = c; code_len = l; code_valid = 1'b1;
    for (int i = 0; i < 20 && !code_ready; i++) step();
    chk("send_ready", code_ready, 1);
    step();
    code_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; code_in = '0; code_len = '0; code_valid = 1'b0;
    flush_req = 1'b0; word_ready = 1'b1;
    #3;
    chk("rst_word_valid", word_valid, 0);
    chk("rst_code_ready", code_ready, 1);
    chk("rst_word_count", word_count, 0);
    chk("rst_len_err",    len_err, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_word_out",   word_out, 0);
    step();
    rst = 1'b1;
    step();

    // 1: eight 4'hA codes -> one AAAAAAAA word
    for (int i = 0; i < 8; i++) send(26'hA, 5'd4);
    chk("t1_valid", word_valid, 1);
    chk("t1_word",  word_out, 32'hAAAAAAAA);
    chk("t1_last",  word_last, 0);
    step();
    chk("t1_count", word_count, 1);
    chk("t1_empty", word_valid, 0);

    // 2: 26 ones + 6 zeros, then flush with nothing buffered
    send(26'h3FFFFFF, 5'd26);
    send(26'h0, 5'd6);
    chk("t2_word", word_out, 32'hFFFFFFC0);
    step();
    chk("t2_count", word_count, 2);
    flush_req = 1'b1; step(); flush_req = 1'b0;
    chk("t2_pad_novalid", word_valid, 0);
    chk("t2_pad_nodone",  flush_done, 0);
    step();
    chk("t2_done",       flush_done, 1);
    chk("t2_done_novld", word_valid, 0);
    step();
    chk("t2_done_pulse", flush_done, 0);
    chk("t2_count_hold", word_count, 2);

    // 3: 3'b101 together with flush -> padded BFFFFFFF, last
    word_ready = 1'b0;
    code_in = 26'h5; code_len = 5'd3; code_valid = 1'b1; flush_req = 1'b1;
    step();
    code_valid = 1'b0; flush_req = 1'b0;
    chk("t3_pad_notready", code_ready, 0);
    step();
    chk("t3_valid", word_valid, 1);
    chk("t3_word",  word_out, 32'hBFFFFFFF);
    chk("t3_last",  word_last, 1);
    chk("t3_nodone", flush_done, 0);
    word_ready = 1'b1;
    step();
    chk("t3_done",  flush_done, 1);
    chk("t3_count", word_count, 3);
    step();
    chk("t3_done_pulse", flush_done, 0);
    chk("t3_run_ready",  code_ready, 1);

    // 4: backpressure with 26-bit codes
    word_ready = 1'b0;
    send(26'h2AAAAAA, 5'd26);
    send(26'h1555555, 5'd26);
    chk("t4_stall_ready", code_ready, 0);
    chk("t4_word0", word_out, 32'hAAAAAA95);
    code_in = 26'hABC; code_len = 5'd12; code_valid = 1'b1;
    step(); step();
    chk("t4_hold_ready", code_ready, 0);
    chk("t4_hold_word",  word_out, 32'hAAAAAA95);
    chk("t4_hold_count", word_count, 3);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    chk("t4_count4", word_count, 4);
    chk("t4_ready_again", code_ready, 1);
    chk("t4_partial", word_valid, 0);
    step();
    code_valid = 1'b0;
    chk("t4_valid1", word_valid, 1);
    chk("t4_word1",  word_out, 32'h55555ABC);
    word_ready = 1'b1;
    step();
    chk("t4_count5", word_count, 5);

    // 5: len 27 dropped and flagged, len 0 ignored, high code bits masked
    word_ready = 1'b0;
    send(26'h3FFFFFF, 5'd4);
    chk("t5_noerr", len_err, 0);
    send(26'h3FFFFFF, 5'd27);
    chk("t5_err", len_err, 1);
    send(26'h3FFFFFF, 5'd0);
    send(26'h2AAAAAA, 5'd26);
    chk("t5_fill30", word_valid, 0);
    send(26'h3FFFFFD, 5'd2);
    chk("t5_word", word_out, 32'hFAAAAAA9);
    word_ready = 1'b1;
    step();
    chk("t5_count", word_count, 6);
    chk("t5_sticky", len_err, 1);

    // 6: async reset while draining
    word_ready = 1'b0;
    send(26'h3FFFFFF, 5'd26);
    send(26'h3FFFFFF, 5'd26);
    flush_req = 1'b1; step(); flush_req = 1'b0;
    step();
    chk("t6_drain_valid", word_valid, 1);
    chk("t6_drain_last",  word_last, 0);
    chk("t6_drain_word",  word_out, 32'hFFFFFFFF);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", word_valid, 0);
    chk("t6_rst_count", word_count, 0);
    chk("t6_rst_err",   len_err, 0);
    @(posedge clk_0); #1;
    rst = 1'b1;
    word_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_no_done", flush_done, 0);
    end
    chk("t6_empty", word_valid, 0);
    chk("t6_ready", code_ready, 1);
    chk("t6_count", word_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
